instr_fetch_unit: RTL and testbench



---
 rtl/fetch_pkg.sv | 12 +
 rtl/fetch_fifo.sv | 56 +++++
 rtl/instr_fetch_unit.sv | 93 +++++++++
 tb/tb_instr_fetch_unit.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared widths, the prefetch entry layout and the default reset PC for the fetch stage.
package fetch_pkg;
  localparam int XLEN = 32;
  localparam int ILEN = 32;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of fetch entries; a write is visible at the head one edge later.
// Full rejects pushes unless a pop happens on the same edge; flush empties it.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t wdata,
  input  logic         pop,
  output fetch_entry_t rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  fetch_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  logic w_do_pop;
  logic w_do_push;

  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is left unreset; the count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (w_do_push && !flush && !rst) r_mem[r_wr_ptr] <= wdata;
  end

  assign full  = (r_count == FULL_CNT);
  assign empty = (r_count == '0);
  assign rdata = empty ? '0 : r_mem[r_rd_ptr];
endmodule

// File: rtl/instr_fetch_unit.sv
// PC owner feeding a combinational imem into a prefetch FIFO; head visible 1 edge after fetch, 1 instr/cycle.
// Stalls on full FIFO or fetch_en=0; redirect flushes. FETCH_PERF_CNT_EN adds push/redirect counters.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_redirects,
`endif
  output logic        fetch_misalign
);
  logic [31:0]  r_pc;
  logic [31:0]  w_pc_nxt;
  logic         r_misalign;
  logic         w_pop;
  logic         w_push;
  logic         w_full;
  logic         w_empty;
  fetch_entry_t w_wdata;
  fetch_entry_t w_rdata;

  assign w_pop   = out_valid & out_ready;
  assign w_push  = fetch_en & ~redirect_valid & (~w_full | w_pop);
  assign w_wdata = '{pc: r_pc, instr: imem_rdata};

  always_comb begin
    w_pc_nxt = r_pc;
    if (redirect_valid) w_pc_nxt = {redirect_target[31:2], 2'b00};
    else if (w_push)    w_pc_nxt = r_pc + 32'd4;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc       <= RESET_PC;
      r_misalign <= 1'b0;
    end else begin
      r_pc       <= w_pc_nxt;
      r_misalign <= redirect_valid & (|redirect_target[1:0]);
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_valid),
    .push  (w_push),
    .wdata (w_wdata),
    .pop   (w_pop),
    .rdata (w_rdata),
    .full  (w_full),
    .empty (w_empty)
  );

  assign imem_addr      = r_pc;
  assign out_valid      = ~w_empty;
  assign out_pc         = w_rdata.pc;
  assign out_instr      = w_rdata.instr;
  assign fetch_misalign = r_misalign;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_redirects;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_fetched   <= '0;
      r_perf_redirects <= '0;
    end else begin
      if (w_push)         r_perf_fetched   <= r_perf_fetched + 32'd1;
      if (redirect_valid) r_perf_redirects <= r_perf_redirects + 32'd1;
    end
  end

  assign perf_fetched   = r_perf_fetched;
  assign perf_redirects = r_perf_redirects;
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with RESET_PC=0x100; memory word i reads 0xA000_0000+i.
module tb_instr_fetch_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        fetch_misalign;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_redirects;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return 32'hA000_0000 + (addr >> 2);
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  instr_fetch_unit #(
    .RESET_PC(32'h0000_0100),
    .DEPTH   (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_en       (fetch_en),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
`ifdef FETCH_PERF_CNT_EN
    .perf_fetched   (perf_fetched),
    .perf_redirects (perf_redirects),
`endif
    .fetch_misalign (fetch_misalign)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    step(2);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; fetch_en = 1'b1; out_ready = 1'b1;
    redirect_valid = 1'b0; redirect_target = 32'h0;

    // Reset state and streaming from RESET_PC
    step(2);
    check("rst_valid",    {31'd0, out_valid}, 32'd0);
    check("rst_pc",       out_pc, 32'h0);
    check("rst_instr",    out_instr, 32'h0);
    check("rst_addr",     imem_addr, 32'h100);
    check("rst_misalign", {31'd0, fetch_misalign}, 32'd0);
    rst = 1'b0;
    step(1);
    check("first_valid", {31'd0, out_valid}, 32'd1);
    check("first_pc",    out_pc, 32'h100);
    check("first_instr", out_instr, 32'hA000_0040);
    step(1);
    check("stream_pc1", out_pc, 32'h104);
    step(1);
    check("stream_pc2", out_pc, 32'h108);
    check("stream_ins2", out_instr, 32'hA000_0042);

    // Backpressure: FIFO fills to two entries and the PC holds
    out_ready = 1'b0;
    do_reset();
    step(5);
    check("bp_valid", {31'd0, out_valid}, 32'd1);
    check("bp_head",  out_pc, 32'h100);
    check("bp_addr",  imem_addr, 32'h108);
    out_ready = 1'b1;
    step(1);
    check("bp_drain1", out_pc, 32'h104);
    step(1);
    check("bp_drain2", out_pc, 32'h108);
    check("bp_drain2i", out_instr, 32'hA000_0042);

    // Redirect while full discards buffered entries
    out_ready = 1'b0;
    do_reset();
    step(3);
    redirect_valid = 1'b1; redirect_target = 32'h200;
    step(1);
    redirect_valid = 1'b0; out_ready = 1'b1;
    check("rd_flush_valid", {31'd0, out_valid}, 32'd0);
    check("rd_addr",        imem_addr, 32'h200);
    step(1);
    check("rd_valid", {31'd0, out_valid}, 32'd1);
    check("rd_pc",    out_pc, 32'h200);
    step(1);
    check("rd_pc2",   out_pc, 32'h204);

    // Misaligned redirect target
    redirect_valid = 1'b1; redirect_target = 32'h203;
    step(1);
    redirect_valid = 1'b0;
    check("mis_pulse", {31'd0, fetch_misalign}, 32'd1);
    check("mis_addr",  imem_addr, 32'h200);
    step(1);
    check("mis_clear", {31'd0, fetch_misalign}, 32'd0);
    check("mis_pc",    out_pc, 32'h200);

    // PC wrap at the top of the address space
    redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
    step(1);
    redirect_valid = 1'b0;
    step(1);
    check("wrap_pc0",  out_pc, 32'hFFFF_FFFC);
    check("wrap_ins0", out_instr, 32'hDFFF_FFFF);
    step(1);
    check("wrap_pc1",  out_pc, 32'h0);
    check("wrap_ins1", out_instr, 32'hA000_0000);

    // Reset overrides a concurrent redirect with the FIFO full
    out_ready = 1'b0;
    step(3);
    check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    rst = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h203;
    step(1);
    check("rr_valid",    {31'd0, out_valid}, 32'd0);
    check("rr_addr",     imem_addr, 32'h100);
    check("rr_misalign", {31'd0, fetch_misalign}, 32'd0);
    redirect_valid = 1'b0;
    rst = 1'b0;

    // fetch_en low: nothing is fetched and the PC holds
    fetch_en = 1'b0; out_ready = 1'b1;
    step(3);
    check("halt_valid", {31'd0, out_valid}, 32'd0);
    check("halt_addr",  imem_addr, 32'h100);
    fetch_en = 1'b1;
    step(1);
    check("resume_pc", out_pc, 32'h100);

`ifdef FETCH_PERF_CNT_EN
    do_reset();
    check("perf_f0", perf_fetched, 32'd0);
    check("perf_r0", perf_redirects, 32'd0);
    step(10);
    redirect_valid = 1'b1; redirect_target = 32'h300;
    step(1);
    redirect_valid = 1'b0; fetch_en = 1'b0;
    step(1);
    check("perf_f10", perf_fetched, 32'd10);
    check("perf_r1",  perf_redirects, 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
